// File: rtl/loop_sram_ctrl_if.sv
// Sample-strobe bus between the last effect stage, the loop recorder and the DAC path.
// master = upstream/bench side, slave = loop_sram_ctrl side.
interface loop_sram_ctrl_if;
    logic        i_valid;
    logic [15:0] i_data;
    logic        o_valid;
    logic [15:0] o_data;

    modport master (
        output i_valid,
        output i_data,
        input  o_valid,
        input  o_data
    );

    modport slave (
        input  i_valid,
        input  i_data,
        output o_valid,
        output o_data
    );
endinterface

// File: rtl/loop_sram_ctrl.sv
// Loop recorder/player: records samples into SRAM, then plays them back mixed with the live input.
// Optional LOOP_OVERDUB_EN: in loop mode the saturated mix is written back over the played word.
module loop_sram_ctrl #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DEPTH  = 1048576
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    loop_sram_ctrl_if.slave       smp_bus,
    input  logic                  i_toggle,
    output logic [1:0]            o_mode,
    output logic [ADDR_W:0]       o_loop_len,
    output logic                  o_full,
    output logic [ADDR_W-1:0]     o_SRAM_ADDR,
    inout  wire  [15:0]           io_SRAM_DQ,
    output logic                  o_SRAM_WE_N,
    output logic                  o_SRAM_CE_N,
    output logic                  o_SRAM_OE_N,
    output logic                  o_SRAM_LB_N,
    output logic                  o_SRAM_UB_N
);

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_REC  = 2'd1,
        MODE_LOOP = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2
    } op_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    mode_t             mode_q, mode_d;
    op_t               op_q, op_d;
    logic [2:0]        phase_q, phase_d;
    logic              toggle_pend_q, toggle_pend_d;
    logic [15:0]       smp_q, smp_d;
    logic [15:0]       loop_q, loop_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   loop_len_q, loop_len_d;
    logic              full_q, full_d;
    logic              o_valid_q, o_valid_d;
    logic [15:0]       o_data_q, o_data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       dq_out_q, dq_out_d;
    logic              dq_oe_q, dq_oe_d;
    logic              we_n_q, we_n_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              bytes_n_q, bytes_n_d;

    logic              accept;
    logic              toggle_req;
    logic              toggle_apply;
    logic [ADDR_W:0]   wr_inc;
    logic [ADDR_W:0]   rd_inc;
    logic [ADDR_W:0]   rd_next;
    logic [16:0]       mix_sum;
    logic [15:0]       mix_sat;

    always_comb begin
        mix_sum = {smp_q[15], smp_q} + {loop_q[15], loop_q};
        if (mix_sum[16] != mix_sum[15]) begin
            mix_sat = mix_sum[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            mix_sat = mix_sum[15:0];
        end
    end

    always_comb begin
        mode_d        = mode_q;
        op_d          = op_q;
        smp_d         = smp_q;
        loop_d        = loop_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        loop_len_d    = loop_len_q;
        full_d        = full_q;
        o_valid_d     = 1'b0;
        o_data_d      = o_data_q;
        addr_d        = addr_q;
        dq_out_d      = dq_out_q;
        dq_oe_d       = dq_oe_q;
        we_n_d        = we_n_q;
        ce_n_d        = ce_n_q;
        oe_n_d        = oe_n_q;
        bytes_n_d     = bytes_n_q;

        wr_inc  = wr_ptr_q + PTR_ONE;
        rd_inc  = rd_ptr_q + PTR_ONE;
        rd_next = (rd_inc == loop_len_q) ? '0 : rd_inc;

        // The sequence always runs six cycles so strobe spacing is mode independent.
        accept = smp_bus.i_valid && (phase_q == 3'd0);
        if (accept) begin
            phase_d = 3'd1;
        end else if (phase_q != 3'd0) begin
            phase_d = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
        end else begin
            phase_d = 3'd0;
        end

        case (phase_q)
            3'd0: begin
                if (accept) begin
                    smp_d = smp_bus.i_data;
                    op_d  = OP_PASS;
                    if (mode_q == MODE_REC && !full_q) begin
                        op_d      = OP_WR;
                        addr_d    = wr_ptr_q[ADDR_W-1:0];
                        dq_out_d  = smp_bus.i_data;
                        dq_oe_d   = 1'b1;
                        ce_n_d    = 1'b0;
                        bytes_n_d = 1'b0;
                        we_n_d    = 1'b0;
                    end else if (mode_q == MODE_LOOP) begin
                        op_d      = OP_RD;
                        addr_d    = rd_ptr_q[ADDR_W-1:0];
                        ce_n_d    = 1'b0;
                        bytes_n_d = 1'b0;
                        oe_n_d    = 1'b0;
                    end
                end
            end
            3'd1: begin
                if (op_q == OP_WR) begin
                    we_n_d = 1'b1;
                end else if (op_q == OP_RD) begin
                    loop_d = io_SRAM_DQ;
                    oe_n_d = 1'b1;
                end
            end
            3'd2: begin
                ce_n_d    = 1'b1;
                we_n_d    = 1'b1;
                oe_n_d    = 1'b1;
                bytes_n_d = 1'b1;
                dq_oe_d   = 1'b0;
                o_valid_d = 1'b1;
                o_data_d  = (op_q == OP_RD) ? mix_sat : smp_q;
                if (op_q == OP_WR) begin
                    wr_ptr_d = wr_inc;
                    if (wr_inc == DEPTH_W) begin
                        full_d = 1'b1;
                    end
                end
`ifdef LOOP_OVERDUB_EN
                if (op_q == OP_RD) begin
                    addr_d    = rd_ptr_q[ADDR_W-1:0];
                    dq_out_d  = mix_sat;
                    dq_oe_d   = 1'b1;
                    ce_n_d    = 1'b0;
                    bytes_n_d = 1'b0;
                    we_n_d    = 1'b0;
                end
`else
                if (op_q == OP_RD) begin
                    rd_ptr_d = rd_next;
                end
`endif
            end
`ifdef LOOP_OVERDUB_EN
            3'd3: begin
                if (op_q == OP_RD) begin
                    we_n_d = 1'b1;
                end
            end
            3'd4: begin
                if (op_q == OP_RD) begin
                    ce_n_d    = 1'b1;
                    bytes_n_d = 1'b1;
                    dq_oe_d   = 1'b0;
                    rd_ptr_d  = rd_next;
                end
            end
`endif
            default: begin
            end
        endcase

        // Toggles are deferred until the sample in flight has produced its output.
        toggle_req    = i_toggle || toggle_pend_q;
        toggle_apply  = toggle_req && ((phase_q == 3'd0 && !smp_bus.i_valid) || phase_q >= 3'd3);
        toggle_pend_d = toggle_req && !toggle_apply;

        if (toggle_apply) begin
            case (mode_q)
                MODE_IDLE: begin
                    mode_d     = MODE_REC;
                    wr_ptr_d   = '0;
                    full_d     = 1'b0;
                    loop_len_d = '0;
                end
                MODE_REC: begin
                    if (wr_ptr_d == '0) begin
                        mode_d = MODE_IDLE;
                    end else begin
                        mode_d     = MODE_LOOP;
                        loop_len_d = wr_ptr_d;
                        rd_ptr_d   = '0;
                    end
                end
                default: begin
                    mode_d = MODE_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q        <= MODE_IDLE;
            op_q          <= OP_PASS;
            phase_q       <= '0;
            toggle_pend_q <= 1'b0;
            smp_q         <= '0;
            loop_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            loop_len_q    <= '0;
            full_q        <= 1'b0;
            o_valid_q     <= 1'b0;
            o_data_q      <= '0;
            addr_q        <= '0;
            dq_out_q      <= '0;
            dq_oe_q       <= 1'b0;
            we_n_q        <= 1'b1;
            ce_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
            bytes_n_q     <= 1'b1;
        end else begin
            mode_q        <= mode_d;
            op_q          <= op_d;
            phase_q       <= phase_d;
            toggle_pend_q <= toggle_pend_d;
            smp_q         <= smp_d;
            loop_q        <= loop_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            loop_len_q    <= loop_len_d;
            full_q        <= full_d;
            o_valid_q     <= o_valid_d;
            o_data_q      <= o_data_d;
            addr_q        <= addr_d;
            dq_out_q      <= dq_out_d;
            dq_oe_q       <= dq_oe_d;
            we_n_q        <= we_n_d;
            ce_n_q        <= ce_n_d;
            oe_n_q        <= oe_n_d;
            bytes_n_q     <= bytes_n_d;
        end
    end

    assign smp_bus.o_valid = o_valid_q;
    assign smp_bus.o_data  = o_data_q;
    assign o_mode          = mode_q;
    assign o_loop_len      = loop_len_q;
    assign o_full          = full_q;
    assign o_SRAM_ADDR     = addr_q;
    assign io_SRAM_DQ      = dq_oe_q ? dq_out_q : 'z;
    assign o_SRAM_WE_N     = we_n_q;
    assign o_SRAM_CE_N     = ce_n_q;
    assign o_SRAM_OE_N     = oe_n_q;
    assign o_SRAM_LB_N     = bytes_n_q;
    assign o_SRAM_UB_N     = bytes_n_q;

endmodule

// File: tb/tb_loop_sram_ctrl.sv
// Directed bench for loop_sram_ctrl (ADDR_W=4, DEPTH=8) with a behavioural SRAM on the DQ bus.
// Overdub expectations are selected by LOOP_OVERDUB_EN, matching the DUT build.
module tb_loop_sram_ctrl;

    localparam int unsigned AW = 4;

    logic          clk;
    logic          rst_n;
    logic          toggle;
    logic [1:0]    mode;
    logic [AW:0]   loop_len;
    logic          full;
    logic [AW-1:0] addr;
    wire  [15:0]   sram_dq;
    logic          we_n, ce_n, oe_n, lb_n, ub_n;

    logic [15:0]   mem [0:15];
    int            total = 0;
    int            bad = 0;
    int            wr_count = 0;
    int            strobe_count = 0;

    loop_sram_ctrl_if sbus ();

    loop_sram_ctrl #(.ADDR_W(AW), .DEPTH(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .smp_bus     (sbus.slave),
        .i_toggle    (toggle),
        .o_mode      (mode),
        .o_loop_len  (loop_len),
        .o_full      (full),
        .o_SRAM_ADDR (addr),
        .io_SRAM_DQ  (sram_dq),
        .o_SRAM_WE_N (we_n),
        .o_SRAM_CE_N (ce_n),
        .o_SRAM_OE_N (oe_n),
        .o_SRAM_LB_N (lb_n),
        .o_SRAM_UB_N (ub_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[addr] : 16'hzzzz;

    always @(negedge clk) begin
        if (rst_n && !ce_n && !lb_n && !ub_n) strobe_count++;
        if (rst_n && !ce_n && !we_n) begin
            mem[addr] = sram_dq;
            wr_count++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, bench did not complete");
        $fatal(1, "watchdog");
    end

    task automatic pulse_toggle();
        toggle = 1'b1;
        @(negedge clk);
        toggle = 1'b0;
    endtask

    // One accepted sample, returns o_valid pattern at k+1..k+3, o_data at k+3, mode at k+3/k+4.
    task automatic do_sample(input logic [15:0] d, input logic tog, input logic tog2,
                             output logic [2:0] vpat, output logic [15:0] q,
                             output logic [1:0] m3, output logic [1:0] m4);
        sbus.i_valid = 1'b1;
        sbus.i_data  = d;
        toggle       = tog;
        @(negedge clk);
        sbus.i_valid = 1'b0;
        toggle       = tog2;
        vpat[2]      = sbus.o_valid;
        @(negedge clk);
        toggle       = 1'b0;
        vpat[1]      = sbus.o_valid;
        @(negedge clk);
        vpat[0]      = sbus.o_valid;
        q            = sbus.o_data;
        m3           = mode;
        @(negedge clk);
        m4           = mode;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({mode, loop_len, full, sbus.o_valid, sbus.o_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs mode=%0d len=%0d full=%b valid=%b data=%h want all zero",
                     mode, loop_len, full, sbus.o_valid, sbus.o_data);
        end
        total++;
        if ({we_n, ce_n, oe_n, lb_n, ub_n, addr} !== {5'b11111, 4'd0}) begin
            bad++;
            $display("FAIL reset_sram strobes=%b addr=%0d want strobes=11111 addr=0",
                     {we_n, ce_n, oe_n, lb_n, ub_n}, addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_passthrough();
        logic [2:0] vp; logic [15:0] q; logic [1:0] m3, m4;
        int s0;
        s0 = strobe_count;
        do_sample(16'd1234, 1'b0, 1'b0, vp, q, m3, m4);
        total++;
        if (vp !== 3'b001 || q !== 16'd1234) begin
            bad++;
            $display("FAIL idle_pass valid=%b data=%0d want valid=001 data=1234", vp, q);
        end
        total++;
        if (strobe_count - s0 !== 0) begin
            bad++;
            $display("FAIL idle_no_sram strobes=%0d want 0", strobe_count - s0);
        end
    endtask

    task automatic test_empty();
        int s0;
        s0 = strobe_count;
        pulse_toggle();
        total++;
        if (mode !== 2'd1) begin
            bad++;
            $display("FAIL empty_rec mode=%0d want 1", mode);
        end
        pulse_toggle();
        @(negedge clk);
        total++;
        if (mode !== 2'd0 || loop_len !== '0 || strobe_count - s0 !== 0) begin
            bad++;
            $display("FAIL empty_idle mode=%0d len=%0d strobes=%0d want mode=0 len=0 strobes=0",
                     mode, loop_len, strobe_count - s0);
        end
    endtask

    task automatic test_record_loop();
        logic [15:0] rec_v [4];
        logic [15:0] play_v [5];
        logic [2:0] vp; logic [15:0] q; logic [1:0] m3, m4;
        int w0;
        rec_v  = '{16'd100, 16'd200, -16'sd300, 16'd400};
        play_v = '{16'd100, 16'd200, -16'sd300, 16'd400, 16'd100};
        pulse_toggle();
        w0 = wr_count;
        for (int i = 0; i < 4; i++) begin
            do_sample(rec_v[i], 1'b0, 1'b0, vp, q, m3, m4);
            total++;
            if (vp !== 3'b001 || q !== rec_v[i]) begin
                bad++;
                $display("FAIL rec_pass[%0d] valid=%b data=%0d want valid=001 data=%0d",
                         i, vp, $signed(q), $signed(rec_v[i]));
            end
        end
        total++;
        if (wr_count - w0 !== 4 || mem[0] !== 16'd100 || mem[2] !== -16'sd300 || mem[3] !== 16'd400) begin
            bad++;
            $display("FAIL rec_mem writes=%0d m0=%0d m2=%0d m3=%0d want 4 100 -300 400",
                     wr_count - w0, $signed(mem[0]), $signed(mem[2]), $signed(mem[3]));
        end
        pulse_toggle();
        total++;
        if (mode !== 2'd2 || loop_len !== 5'd4) begin
            bad++;
            $display("FAIL loop_enter mode=%0d len=%0d want mode=2 len=4", mode, loop_len);
        end
        for (int i = 0; i < 5; i++) begin
            do_sample(16'd0, 1'b0, 1'b0, vp, q, m3, m4);
            total++;
            if (vp !== 3'b001 || q !== play_v[i]) begin
                bad++;
                $display("FAIL loop_play[%0d] valid=%b data=%0d want valid=001 data=%0d",
                         i, vp, $signed(q), $signed(play_v[i]));
            end
        end
        pulse_toggle();
        total++;
        if (mode !== 2'd0 || loop_len !== 5'd4) begin
            bad++;
            $display("FAIL loop_exit mode=%0d len=%0d want mode=0 len=4", mode, loop_len);
        end
    endtask

    task automatic test_saturation();
        logic [2:0] vp; logic [15:0] q; logic [1:0] m3, m4;
        pulse_toggle();
        do_sample(16'd30000, 1'b0, 1'b0, vp, q, m3, m4);
        do_sample(-16'sd30000, 1'b0, 1'b0, vp, q, m3, m4);
        pulse_toggle();
        do_sample(16'd10000, 1'b0, 1'b0, vp, q, m3, m4);
        total++;
        if (q !== 16'h7FFF) begin
            bad++;
            $display("FAIL sat_pos data=%0d want 32767", $signed(q));
        end
        do_sample(-16'sd10000, 1'b0, 1'b0, vp, q, m3, m4);
        total++;
        if (q !== 16'h8000) begin
            bad++;
            $display("FAIL sat_neg data=%0d want -32768", $signed(q));
        end
        pulse_toggle();
    endtask

    task automatic test_full();
        logic [2:0] vp; logic [15:0] q; logic [1:0] m3, m4;
        int w0;
        pulse_toggle();
        w0 = wr_count;
        for (int i = 1; i <= 10; i++) begin
            do_sample(16'(i), 1'b0, 1'b0, vp, q, m3, m4);
            if (i >= 9) begin
                total++;
                if (vp !== 3'b001 || q !== 16'(i)) begin
                    bad++;
                    $display("FAIL full_pass[%0d] valid=%b data=%0d want valid=001 data=%0d", i, vp, q, i);
                end
            end
        end
        total++;
        if (wr_count - w0 !== 8 || full !== 1'b1 || mode !== 2'd1) begin
            bad++;
            $display("FAIL full_state writes=%0d full=%b mode=%0d want writes=8 full=1 mode=1",
                     wr_count - w0, full, mode);
        end
        pulse_toggle();
        total++;
        if (mode !== 2'd2 || loop_len !== 5'd8) begin
            bad++;
            $display("FAIL full_len mode=%0d len=%0d want mode=2 len=8", mode, loop_len);
        end
        do_sample(16'd0, 1'b0, 1'b0, vp, q, m3, m4);
        total++;
        if (q !== 16'd1) begin
            bad++;
            $display("FAIL full_play data=%0d want 1", q);
        end
        pulse_toggle();
    endtask

    task automatic test_simultaneous();
        logic [2:0] vp; logic [15:0] q; logic [1:0] m3, m4;
        int w0;
        pulse_toggle();
        w0 = wr_count;
        do_sample(16'd11, 1'b0, 1'b0, vp, q, m3, m4);
        // toggle coincident with i_valid, plus a second toggle at k+1 that must be dropped
        do_sample(16'd22, 1'b1, 1'b1, vp, q, m3, m4);
        total++;
        if (vp !== 3'b001 || q !== 16'd22 || m3 !== 2'd1 || m4 !== 2'd2) begin
            bad++;
            $display("FAIL simul_timing valid=%b data=%0d mode_k3=%0d mode_k4=%0d want 001 22 1 2",
                     vp, q, m3, m4);
        end
        total++;
        if (wr_count - w0 !== 2 || loop_len !== 5'd2 || mode !== 2'd2) begin
            bad++;
            $display("FAIL simul_len writes=%0d len=%0d mode=%0d want 2 2 2", wr_count - w0, loop_len, mode);
        end
        do_sample(16'd0, 1'b0, 1'b0, vp, q, m3, m4);
        do_sample(16'd0, 1'b0, 1'b0, vp, q, m3, m4);
        total++;
        if (q !== 16'd22) begin
            bad++;
            $display("FAIL simul_play data=%0d want 22", q);
        end
    endtask

    task automatic test_reset_mid_access();
        // starts in LOOP with loop_len=2: reset during a read
        sbus.i_valid = 1'b1;
        sbus.i_data  = 16'd5;
        @(negedge clk);
        sbus.i_valid = 1'b0;
        total++;
        if (oe_n !== 1'b0 || ce_n !== 1'b0) begin
            bad++;
            $display("FAIL rst_rd_active oe_n=%b ce_n=%b want 0 0", oe_n, ce_n);
        end
        #1 rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({oe_n, ce_n, we_n} !== 3'b111 || mode !== 2'd0 || loop_len !== '0 || sbus.o_data !== '0) begin
            bad++;
            $display("FAIL rst_rd strobes=%b mode=%0d len=%0d data=%0d want 111 0 0 0",
                     {oe_n, ce_n, we_n}, mode, loop_len, sbus.o_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        pulse_toggle();
        sbus.i_valid = 1'b1;
        sbus.i_data  = 16'd777;
        @(negedge clk);
        sbus.i_valid = 1'b0;
        total++;
        if (we_n !== 1'b0 || ce_n !== 1'b0) begin
            bad++;
            $display("FAIL rst_wr_active we_n=%b ce_n=%b want 0 0", we_n, ce_n);
        end
        #1 rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({we_n, ce_n, oe_n, lb_n, ub_n} !== 5'b11111 || addr !== '0 || mode !== 2'd0 ||
            loop_len !== '0 || sbus.o_valid !== 1'b0 || full !== 1'b0) begin
            bad++;
            $display("FAIL rst_wr strobes=%b addr=%0d mode=%0d len=%0d valid=%b full=%b want 11111 0 0 0 0 0",
                     {we_n, ce_n, oe_n, lb_n, ub_n}, addr, mode, loop_len, sbus.o_valid, full);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int vcount;
        vcount = 0;
        sbus.i_valid = 1'b1;
        sbus.i_data  = 16'd5;
        @(negedge clk);
        sbus.i_valid = 1'b0;
        vcount += int'(sbus.o_valid);
        @(negedge clk);
        vcount += int'(sbus.o_valid);
        @(negedge clk);
        vcount += int'(sbus.o_valid);
        sbus.i_valid = 1'b1;
        sbus.i_data  = 16'd9;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sbus.i_valid = 1'b0;
            vcount += int'(sbus.o_valid);
        end
        total++;
        if (vcount !== 1 || sbus.o_data !== 16'd5) begin
            bad++;
            $display("FAIL back_to_back valids=%0d data=%0d want valids=1 data=5", vcount, sbus.o_data);
        end
    endtask

    task automatic test_loop_write_back();
        logic [2:0] vp; logic [15:0] q1, q2; logic [1:0] m3, m4;
        pulse_toggle();
        do_sample(16'd50, 1'b0, 1'b0, vp, q1, m3, m4);
        pulse_toggle();
        do_sample(16'd20, 1'b0, 1'b0, vp, q1, m3, m4);
        do_sample(16'd20, 1'b0, 1'b0, vp, q2, m3, m4);
`ifdef LOOP_OVERDUB_EN
        total++;
        if (q1 !== 16'd70 || q2 !== 16'd90 || mem[0] !== 16'd90) begin
            bad++;
            $display("FAIL overdub data1=%0d data2=%0d mem0=%0d want 70 90 90", q1, q2, mem[0]);
        end
`else
        total++;
        if (q1 !== 16'd70 || q2 !== 16'd70 || mem[0] !== 16'd50) begin
            bad++;
            $display("FAIL loop_readonly data1=%0d data2=%0d mem0=%0d want 70 70 50", q1, q2, mem[0]);
        end
`endif
        pulse_toggle();
    endtask

    initial begin
        rst_n        = 1'b0;
        toggle       = 1'b0;
        sbus.i_valid = 1'b0;
        sbus.i_data  = '0;
        for (int i = 0; i < 16; i++) mem[i] = 16'hDEAD;
        @(negedge clk);
        test_reset();
        test_idle_passthrough();
        test_empty();
        test_record_loop();
        test_saturation();
        test_full();
        test_simultaneous();
        test_reset_mid_access();
        test_back_to_back();
        test_loop_write_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
